// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the regfile_mp multi-port register file.
package regfile_mp_pkg;

   // Clear-walk controller states.
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   // Ceiling log2, usable in constant expressions (parameter derivation).
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage : regfile_mp_pkg

// File: rtl/regfile_mp_clr_ctrl.sv
// Clear-walk controller for regfile_mp: owns the CLEAR/READY FSM, the
// walk counter that addresses the entry being zeroed, ready, and wr_drop.
module regfile_mp_clr_ctrl
   import regfile_mp_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          we,
   output logic [AW-1:0] cnt,
   output logic          clearing,
   output logic          ready,
   output logic          wr_drop
);

   localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          wr_drop_q, wr_drop_d;

   // State register: reset lands in CLEAR with the walk at entry 0.
   // NOTE: sequential state uses <= so every flop samples pre-edge values;
   // blocking = here would make the result depend on statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CLEAR;
         cnt_q     <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   // Next state: walk every entry once, clr restarts the walk from 0.
   // NOTE: every variable gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_drop_d = 1'b0;
      unique case (state_q)
         CLEAR: begin
            wr_drop_d = we;
            if (clr) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state_d = READY;
            end
         end
         READY: begin
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // Outputs decoded from the registered state.
   always_comb begin
      clearing = (state_q == CLEAR);
      ready    = (state_q == READY);
      cnt      = cnt_q;
      wr_drop  = wr_drop_q;
   end

endmodule : regfile_mp_clr_ctrl

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardware clear walk and hard-wired
// zero at entry 0. Define REGFILE_MP_BYPASS_EN to forward a same-cycle
// write to any read port addressing the written entry.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int DEPTH  = 8,
   parameter  int NUM_RD = 2,
   localparam int AW     = clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     we,
   input  logic [AW-1:0]            waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [NUM_RD-1:0]        re,
   input  logic [NUM_RD*AW-1:0]     raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic                     ready,
   output logic                     wr_drop
);

   logic [AW-1:0]            cnt;
   logic                     clearing;
   logic [DATA_W-1:0]        mem_q [DEPTH];
   logic                     mem_we;
   logic [AW-1:0]            mem_waddr;
   logic [DATA_W-1:0]        mem_wdata;
   logic [NUM_RD*DATA_W-1:0] rdata_q, rdata_d;

   regfile_mp_clr_ctrl #(.DEPTH(DEPTH)) u_clr_ctrl (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .we       (we),
      .cnt      (cnt),
      .clearing (clearing),
      .ready    (ready),
      .wr_drop  (wr_drop)
   );

   // Single storage write port: the clear walk owns it while clearing,
   // otherwise user writes to non-zero entries.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = waddr;
      mem_wdata = wdata;
      if (clearing) begin
         mem_we    = 1'b1;
         mem_waddr = cnt;
         mem_wdata = '0;
      end else if (we && (waddr != '0)) begin
         mem_we = 1'b1;
      end
   end

   // Storage array update.
   // NOTE: the array has no reset; the clear walk that follows every reset
   // zeroes it, keeping the storage free of per-bit reset wiring.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   // Per-port registered read: zero while clearing, hold when not enabled.
   always_comb begin
      rdata_d = rdata_q;
      for (int p = 0; p < NUM_RD; p++) begin
         if (clearing) begin
            rdata_d[p*DATA_W +: DATA_W] = '0;
         end else if (re[p]) begin
            if (raddr[p*AW +: AW] == '0) begin
               rdata_d[p*DATA_W +: DATA_W] = '0;
`ifdef REGFILE_MP_BYPASS_EN
            end else if (we && (waddr == raddr[p*AW +: AW])) begin
               rdata_d[p*DATA_W +: DATA_W] = wdata;
`endif
            end else begin
               rdata_d[p*DATA_W +: DATA_W] = mem_q[raddr[p*AW +: AW]];
            end
         end
      end
   end

   // Read data register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters). Honours
// REGFILE_MP_BYPASS_EN for the same-cycle forwarding expectation.
module tb_regfile_mp;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int NUM_RD = 2;
   localparam int AW     = 3;
`ifdef REGFILE_MP_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     clr;
   logic                     we;
   logic [AW-1:0]            waddr;
   logic [DATA_W-1:0]        wdata;
   logic [NUM_RD-1:0]        re;
   logic [NUM_RD*AW-1:0]     raddr;
   logic [NUM_RD*DATA_W-1:0] rdata;
   logic                     ready;
   logic                     wr_drop;

   regfile_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .re      (re),
      .raddr   (raddr),
      .rdata   (rdata),
      .ready   (ready),
      .wr_drop (wr_drop)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expected observations, each due after a given edge.
   typedef enum {K_RDATA, K_READY, K_DROP} kind_e;
   typedef struct {
      int                due;
      kind_e             kind;
      int                port;
      logic [DATA_W-1:0] exp;
      string             name;
   } exp_t;
   exp_t sbq[$];

   // Monitor: compare every expectation whose edge has passed.
   always @(negedge clk) begin
      exp_t e;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         e = sbq.pop_front();
         case (e.kind)
            K_RDATA: check(e.name, 32'(rdata[e.port*DATA_W +: DATA_W]), 32'(e.exp));
            K_READY: check(e.name, 32'(ready), 32'(e.exp));
            default: check(e.name, 32'(wr_drop), 32'(e.exp));
         endcase
      end
   end

   // Reference model: clear is a countdown of busy cycles, contents are
   // considered zero as soon as a clear starts.
   logic [DATA_W-1:0] m_mem [DEPTH];
   logic [DATA_W-1:0] m_rd  [NUM_RD];
   int                m_busy;

   task automatic model_reset();
      foreach (m_mem[i]) m_mem[i] = '0;
      foreach (m_rd[i])  m_rd[i]  = '0;
      m_busy = DEPTH;
   endtask

   function automatic exp_t mk(input int due, input kind_e k, input int p,
                               input logic [DATA_W-1:0] v, input string n);
      exp_t e;
      e.due = due; e.kind = k; e.port = p; e.exp = v; e.name = n;
      return e;
   endfunction

   // Drive one cycle of stimulus (called #1 after an edge), predict it.
   task automatic cycle(input logic c, input logic w, input logic [AW-1:0] wa,
                        input logic [DATA_W-1:0] wd, input logic [NUM_RD-1:0] r,
                        input logic [NUM_RD*AW-1:0] ra, input string tag);
      logic          drop;
      logic [AW-1:0] a;
      int            due;
      clr = c; we = w; waddr = wa; wdata = wd; re = r; raddr = ra;
      due = cyc + 1;
      if (m_busy > 0) begin
         drop = w;
         foreach (m_rd[p]) m_rd[p] = '0;
         m_busy = c ? DEPTH : m_busy - 1;
      end else begin
         drop = 1'b0;
         for (int p = 0; p < NUM_RD; p++) begin
            if (r[p]) begin
               a = ra[p*AW +: AW];
               if (a == 0)                      m_rd[p] = '0;
               else if (BYPASS && w && wa == a) m_rd[p] = wd;
               else                             m_rd[p] = m_mem[a];
            end
         end
         if (w && wa != 0) m_mem[wa] = wd;
         if (c) begin
            m_busy = DEPTH;
            foreach (m_mem[i]) m_mem[i] = '0;
         end
      end
      for (int p = 0; p < NUM_RD; p++)
         sbq.push_back(mk(due, K_RDATA, p, m_rd[p], $sformatf("%s rdata%0d", tag, p)));
      sbq.push_back(mk(due, K_READY, 0, DATA_W'(m_busy == 0), {tag, " ready"}));
      sbq.push_back(mk(due, K_DROP, 0, DATA_W'(drop), {tag, " wr_drop"}));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, '0, tag);
   endtask

   task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input string tag);
      cycle(1'b0, 1'b0, '0, '0, 2'b11, {a1, a0}, tag);
   endtask

   // Asynchronous reset: outputs must drop immediately, not at an edge.
   task automatic do_reset(input int hold, input string tag);
      rst = 1'b1;
      clr = 1'b0; we = 1'b0; re = '0;
      sbq.delete();
      model_reset();
      #1;
      check({tag, " rst rdata"}, 32'(rdata), 32'h0);
      check({tag, " rst ready"}, 32'(ready), 32'h0);
      check({tag, " rst wr_drop"}, 32'(wr_drop), 32'h0);
      repeat (hold) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset(2, "init");

      // Reset then clear walk, then every entry reads zero.
      idle(DEPTH, "walk");
      rd2(3'd1, 3'd2, "zero12");
      rd2(3'd3, 3'd4, "zero34");
      rd2(3'd5, 3'd6, "zero56");
      rd2(3'd7, 3'd7, "zero7");

      // Write then read on both ports.
      cycle(1'b0, 1'b1, 3'd3, 16'hBEEF, '0, '0, "wr3");
      rd2(3'd3, 3'd3, "rd3");
      idle(1, "hold");

      // Entry 0 is hard-wired to zero.
      cycle(1'b0, 1'b1, 3'd0, 16'h1234, '0, '0, "wr0");
      rd2(3'd0, 3'd0, "rd0");

      // Same-cycle write and read of r5.
      cycle(1'b0, 1'b1, 3'd5, 16'hA5A5, 2'b11, {3'd5, 3'd5}, "fwd5");
      rd2(3'd5, 3'd3, "rd5");

      // Clear mid-operation with a dropped write.
      cycle(1'b0, 1'b1, 3'd2, 16'h00FF, '0, '0, "wr2");
      cycle(1'b1, 1'b0, '0, '0, 2'b11, {3'd3, 3'd2}, "clr");
      cycle(1'b0, 1'b1, 3'd4, 16'h7777, 2'b11, {3'd4, 3'd2}, "drop4");
      idle(DEPTH - 1, "clrwalk");
      rd2(3'd2, 3'd4, "rd24");

      // Reset from READY with non-zero read data, then mid-CLEAR reset.
      cycle(1'b0, 1'b1, 3'd6, 16'hC0DE, '0, '0, "wr6");
      rd2(3'd6, 3'd6, "rd6");
      do_reset(1, "rdy");
      idle(DEPTH + 1, "walk2");
      cycle(1'b1, 1'b0, '0, '0, '0, '0, "clr2");
      idle(3, "cnt3");
      do_reset(1, "mid");
      idle(DEPTH + 1, "walk3");

      // Randomized traffic with occasional clears and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(599) == 0) begin
            do_reset(1, "rnd");
         end else begin
            cycle($urandom_range(49) == 0, $urandom_range(1) == 1,
                  AW'($urandom_range(DEPTH - 1)), DATA_W'($urandom),
                  NUM_RD'($urandom_range(3)), (NUM_RD*AW)'($urandom), "rnd");
         end
      end

      idle(2, "tail");
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_regfile_mp
